regex_job_sequencer: RTL

//  Hardware host-side driver for AXI_top's register interface. Takes one job as a valid/ready word stream: code segment, then string segment.

---
 rtl/regex_job_sequencer_pkg.sv | 46 ++++
 rtl/regex_job_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regex_job_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// regex_job_sequencer_pkg
//   Shared definitions for the regex job sequencer slice. This package holds the
//   AXI_top register-interface constants the sequencer needs: REG_WIDTH, the
//   CMD_* command codes and the STATUS_* codes. It also holds the sequencer's
//   own state type, the in_bytes width and the default watchdog limit.
//   seq_last_bytes() decodes the in_bytes field of a string last word.
// -----------------------------------------------------------------------------
package regex_job_sequencer_pkg;

    localparam int REG_WIDTH = 32;

    // AXI_top command codes
    localparam logic [REG_WIDTH-1:0] CMD_NOP                = 32'd0;
    localparam logic [REG_WIDTH-1:0] CMD_WRITE              = 32'd1;
    localparam logic [REG_WIDTH-1:0] CMD_START              = 32'd3;
    localparam logic [REG_WIDTH-1:0] CMD_RESET              = 32'd4;
    localparam logic [REG_WIDTH-1:0] CMD_READ_ELAPSED_CLOCK = 32'd5;

    // AXI_top status codes
    localparam logic [REG_WIDTH-1:0] STATUS_RUNNING  = 32'd1;
    localparam logic [REG_WIDTH-1:0] STATUS_ACCEPTED = 32'd2;
    localparam logic [REG_WIDTH-1:0] STATUS_REJECTED = 32'd3;

    localparam int SEQ_BYTES_W         = 2;
    localparam int SEQ_TIMEOUT_DEFAULT = 2**20;

    typedef enum logic [3:0] {
        SEQ_IDLE,
        SEQ_LOAD_CODE,
        SEQ_LOAD_STRING,
        SEQ_START,
        SEQ_WAIT_RUN,
        SEQ_WAIT_DONE,
        SEQ_READ_CC,
        SEQ_CAPTURE_CC,
        SEQ_RESET_CORE,
        SEQ_RESPOND
    } seq_state_t;

    // Valid byte count of a string last word; the value 0 encodes a full word.
    function automatic logic [REG_WIDTH-1:0] seq_last_bytes(input logic [SEQ_BYTES_W-1:0] b);
        return (b == '0) ? REG_WIDTH'(4) : REG_WIDTH'(b);
    endfunction

endpackage

// File: rtl/regex_job_sequencer.sv
// -----------------------------------------------------------------------------
// regex_job_sequencer
//   Host-side driver for AXI_top's register interface. The module accepts one
//   job as a valid/ready word stream: the code segment first, then the string
//   segment. It writes both segments into coprocessor memory and starts a
//   match. It then waits for accept/reject, reads the elapsed-clock count,
//   resets the core and returns one result record.
//
// Parameters
//   MEM_WORDS       coprocessor memory capacity in REG_WIDTH words
//   TIMEOUT_CYCLES  watchdog limit in WAIT_RUN/WAIT_DONE
//
// Optional feature
//   Defining REGEX_SEQ_TIMEOUT_EN adds the watchdog. When it expires, the
//   sequencer flags an error, reports TIMEOUT_CYCLES as the cycle count and
//   resets the core. Without it, the wait states wait indefinitely.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid/in_ready           job word handshake
//   in_data, in_last, in_bytes  job word, end of segment, last-word byte count
//   address_register            word address to AXI_top
//   data_in_register            write data to AXI_top
//   start_cc_pointer_register   string first byte address
//   end_cc_pointer_register     string last byte address (inclusive)
//   cmd_register                command code to AXI_top
//   status_register             status from AXI_top
//   data_o_register             read data from AXI_top
//   res_valid/res_ready         result handshake
//   res_accept, res_error       match accepted / job failed
//   res_cycles                  elapsed clock count reported by the core
// -----------------------------------------------------------------------------
module regex_job_sequencer
    import regex_job_sequencer_pkg::*;
#(
    parameter int MEM_WORDS      = 1024,
    parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [REG_WIDTH-1:0]   in_data,
    input  logic                   in_last,
    input  logic [SEQ_BYTES_W-1:0] in_bytes,
    output logic [REG_WIDTH-1:0]   address_register,
    output logic [REG_WIDTH-1:0]   data_in_register,
    output logic [REG_WIDTH-1:0]   start_cc_pointer_register,
    output logic [REG_WIDTH-1:0]   end_cc_pointer_register,
    output logic [REG_WIDTH-1:0]   cmd_register,
    input  logic [REG_WIDTH-1:0]   status_register,
    input  logic [REG_WIDTH-1:0]   data_o_register,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_accept,
    output logic                   res_error,
    output logic [REG_WIDTH-1:0]   res_cycles
);

    // One extra bit so that wp == MEM_WORDS (memory full) is representable.
    localparam int              WP_W    = $clog2(MEM_WORDS) + 1;
    localparam logic [WP_W-1:0] WP_FULL = WP_W'(MEM_WORDS);

    seq_state_t           state_reg;
    logic [WP_W-1:0]      wp_reg;
    logic [WP_W-1:0]      str_wp_reg;      // word address of the first string word
    logic [REG_WIDTH-1:0] nb_reg;          // string length in bytes
    logic [1:0]           start_phase_reg;
    logic                 err_reg;
    logic                 accept_reg;
    logic [REG_WIDTH-1:0] cycles_reg;

    logic                 xfer;
    logic                 overflow_now;
    logic [WP_W-1:0]      wp_inc;
    logic [REG_WIDTH-1:0] nb_now;

    assign xfer         = in_valid & in_ready;
    assign overflow_now = (wp_reg == WP_FULL);
    // Once memory is full, the pointer stops advancing and later words are dropped.
    assign wp_inc       = overflow_now ? wp_reg : wp_reg + WP_W'(1);
    // Length at the string last word: 4 bytes per earlier string word plus this word's bytes.
    assign nb_now       = (REG_WIDTH'(wp_reg - str_wp_reg) << 2) + seq_last_bytes(in_bytes);

`ifdef REGEX_SEQ_TIMEOUT_EN
    localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_reg;
    logic             tmo_hit;

    assign tmo_hit = (tmo_reg == TMO_LAST) &&
                     ((state_reg == SEQ_WAIT_RUN) || (state_reg == SEQ_WAIT_DONE));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg                 <= SEQ_IDLE;
            wp_reg                    <= '0;
            str_wp_reg                <= '0;
            nb_reg                    <= '0;
            start_phase_reg           <= '0;
            err_reg                   <= 1'b0;
            accept_reg                <= 1'b0;
            cycles_reg                <= '0;
            in_ready                  <= 1'b0;
            address_register          <= '0;
            data_in_register          <= '0;
            start_cc_pointer_register <= '0;
            end_cc_pointer_register   <= '0;
            cmd_register              <= CMD_NOP;
            res_valid                 <= 1'b0;
            res_accept                <= 1'b0;
            res_error                 <= 1'b0;
            res_cycles                <= '0;
`ifdef REGEX_SEQ_TIMEOUT_EN
            tmo_reg                   <= '0;
`endif
        end else begin
            case (state_reg)
                SEQ_IDLE: begin
                    wp_reg          <= '0;
                    err_reg         <= 1'b0;
                    accept_reg      <= 1'b0;
                    cycles_reg      <= '0;
                    start_phase_reg <= '0;
                    cmd_register    <= CMD_NOP;
                    in_ready        <= 1'b1;
                    state_reg       <= SEQ_LOAD_CODE;
                end

                SEQ_LOAD_CODE, SEQ_LOAD_STRING: begin
                    cmd_register <= CMD_NOP;
                    if (xfer) begin
                        if (overflow_now) begin
                            err_reg <= 1'b1;
                        end else begin
                            address_register <= REG_WIDTH'(wp_reg);
                            data_in_register <= in_data;
                            cmd_register     <= CMD_WRITE;
                        end
                        wp_reg <= wp_inc;
                        if (in_last) begin
                            if (state_reg == SEQ_LOAD_CODE) begin
                                str_wp_reg <= wp_inc;
                                state_reg  <= SEQ_LOAD_STRING;
                            end else begin
                                in_ready <= 1'b0;
                                nb_reg   <= nb_now;
                                if (err_reg || overflow_now) begin
                                    // Incomplete job: report the failure without touching the core.
                                    res_valid  <= 1'b1;
                                    res_error  <= 1'b1;
                                    res_accept <= 1'b0;
                                    res_cycles <= '0;
                                    state_reg  <= SEQ_RESPOND;
                                end else begin
                                    start_phase_reg <= '0;
                                    state_reg       <= SEQ_START;
                                end
                            end
                        end
                    end
                end

                // The first cycle in START still shows the final string write.
                // CMD_START is then held for two cycles.
                SEQ_START: begin
                    start_phase_reg <= start_phase_reg + 2'd1;
`ifdef REGEX_SEQ_TIMEOUT_EN
                    tmo_reg <= '0;
`endif
                    case (start_phase_reg)
                        2'd0: begin
                            start_cc_pointer_register <= REG_WIDTH'(str_wp_reg) << 2;
                            end_cc_pointer_register   <= (REG_WIDTH'(str_wp_reg) << 2) + nb_reg - REG_WIDTH'(1);
                            cmd_register              <= CMD_START;
                        end
                        2'd1: cmd_register <= CMD_START;
                        default: begin
                            cmd_register <= CMD_NOP;
                            state_reg    <= SEQ_WAIT_RUN;
                        end
                    endcase
                end

                SEQ_WAIT_RUN: begin
`ifdef REGEX_SEQ_TIMEOUT_EN
                    tmo_reg <= tmo_reg + TMO_W'(1);
`endif
                    if (status_register == STATUS_RUNNING) begin
                        state_reg <= SEQ_WAIT_DONE;
                    end
                end

                SEQ_WAIT_DONE: begin
`ifdef REGEX_SEQ_TIMEOUT_EN
                    tmo_reg <= tmo_reg + TMO_W'(1);
`endif
                    if (status_register != STATUS_RUNNING) begin
                        accept_reg <= (status_register == STATUS_ACCEPTED);
                        if ((status_register != STATUS_ACCEPTED) &&
                            (status_register != STATUS_REJECTED)) begin
                            err_reg <= 1'b1;
                        end
                        cmd_register <= CMD_READ_ELAPSED_CLOCK;
                        state_reg    <= SEQ_READ_CC;
                    end
                end

                SEQ_READ_CC: begin
                    cmd_register <= CMD_NOP;
                    state_reg    <= SEQ_CAPTURE_CC;
                end

                // AXI_top returns the count one cycle after the read command.
                SEQ_CAPTURE_CC: begin
                    cycles_reg   <= data_o_register;
                    cmd_register <= CMD_RESET;
                    state_reg    <= SEQ_RESET_CORE;
                end

                SEQ_RESET_CORE: begin
                    cmd_register <= CMD_NOP;
                    res_valid    <= 1'b1;
                    res_accept   <= accept_reg;
                    res_error    <= err_reg;
                    res_cycles   <= cycles_reg;
                    state_reg    <= SEQ_RESPOND;
                end

                SEQ_RESPOND: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_reg <= SEQ_IDLE;
                    end
                end

                default: state_reg <= SEQ_IDLE;
            endcase

`ifdef REGEX_SEQ_TIMEOUT_EN
            // Watchdog takes priority over a same-cycle status change.
            if (tmo_hit) begin
                err_reg      <= 1'b1;
                accept_reg   <= 1'b0;
                cycles_reg   <= REG_WIDTH'(TIMEOUT_CYCLES);
                cmd_register <= CMD_RESET;
                state_reg    <= SEQ_RESET_CORE;
            end
`endif
        end
    end

endmodule
